// File: rtl/ace_rd_arbiter.sv
// Two-port ACE read arbiter (IFU = port 0, LSU = port 1) with a registered AR slot
// and an owner FIFO that steers in-order R bursts back. Option: ACE_RD_ARB_LSU_PRIO_EN.
module ace_rd_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s0_ar_valid,
    output logic                              s0_ar_ready,
    input  logic [ADDR_WIDTH-1:0]             s0_ar_addr,
    input  logic [7:0]                        s0_ar_len,
    output logic                              s0_r_valid,
    input  logic                              s0_r_ready,
    output logic [DATA_WIDTH-1:0]             s0_r_data,
    output logic [1:0]                        s0_r_resp,
    output logic                              s0_r_last,
    input  logic                              s1_ar_valid,
    output logic                              s1_ar_ready,
    input  logic [ADDR_WIDTH-1:0]             s1_ar_addr,
    input  logic [7:0]                        s1_ar_len,
    output logic                              s1_r_valid,
    input  logic                              s1_r_ready,
    output logic [DATA_WIDTH-1:0]             s1_r_data,
    output logic [1:0]                        s1_r_resp,
    output logic                              s1_r_last,
    output logic                              m_ar_valid,
    input  logic                              m_ar_ready,
    output logic [ADDR_WIDTH-1:0]             m_ar_addr,
    output logic [7:0]                        m_ar_len,
    input  logic                              m_r_valid,
    output logic                              m_r_ready,
    input  logic [DATA_WIDTH-1:0]             m_r_data,
    input  logic [1:0]                        m_r_resp,
    input  logic                              m_r_last,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              err_orphan
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {AR_EMPTY, AR_FULL} ar_state_t;

    ar_state_t             r_ar_state;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [7:0]            r_ar_len;
    logic                  r_owner [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_err_orphan;

    logic w_fifo_empty;
    logic w_head;
    logic w_pop;
    logic w_full_after_pop;
    logic w_can_load;
    logic w_pick1;
    logic w_grant;

    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_owner[r_rd_ptr];

    // R path: the FIFO head owns the current burst; an empty FIFO refuses every beat.
    assign m_r_ready  = !w_fifo_empty && (w_head ? s1_r_ready : s0_r_ready);
    assign s0_r_valid = m_r_valid && !w_fifo_empty && !w_head;
    assign s1_r_valid = m_r_valid && !w_fifo_empty &&  w_head;
    assign s0_r_data  = m_r_data;
    assign s0_r_resp  = m_r_resp;
    assign s0_r_last  = m_r_last;
    assign s1_r_data  = m_r_data;
    assign s1_r_resp  = m_r_resp;
    assign s1_r_last  = m_r_last;

    assign w_pop            = m_r_valid && m_r_ready && m_r_last;
    assign w_full_after_pop = (r_count == DEPTH) && !w_pop;

    assign m_ar_valid = (r_ar_state == AR_FULL);
    assign m_ar_addr  = r_ar_addr;
    assign m_ar_len   = r_ar_len;

    // NOTE: rst gates the grant so no handshake is offered while reset is held,
    // even if a requester already drives valid.
    assign w_can_load = rst && ((r_ar_state == AR_EMPTY) || (m_ar_valid && m_ar_ready))
                        && !w_full_after_pop;

`ifdef ACE_RD_ARB_LSU_PRIO_EN
    assign w_pick1 = s1_ar_valid;
`else
    logic r_rr_ptr;
    assign w_pick1 = s1_ar_valid && (!s0_ar_valid || r_rr_ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_rr_ptr <= 1'b0;
        else if (w_grant) r_rr_ptr <= !w_pick1;
    end
`endif

    assign s0_ar_ready = w_can_load && s0_ar_valid && !w_pick1;
    assign s1_ar_ready = w_can_load && w_pick1;
    assign w_grant     = w_can_load && (s0_ar_valid || s1_ar_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ar_state <= AR_EMPTY;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
        end else if (w_grant) begin
            r_ar_state <= AR_FULL;
            r_ar_addr  <= w_pick1 ? s1_ar_addr : s0_ar_addr;
            r_ar_len   <= w_pick1 ? s1_ar_len  : s0_ar_len;
        end else if (m_ar_valid && m_ar_ready) begin
            r_ar_state <= AR_EMPTY;
        end
    end

    // NOTE: the owner storage has no reset; the reset pointers and count make any
    // stale entry unreachable, and the empty check masks the head read.
    always_ff @(posedge clk) begin
        if (w_grant) r_owner[r_wr_ptr] <= w_pick1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_grant) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
            if (m_r_valid && w_fifo_empty) r_err_orphan <= 1'b1;
        end
    end

    assign outstanding = r_count;
    assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Scoreboard bench for ace_rd_arbiter: expected ARs, beats and owners are queued as
// stimulus is driven and compared when the DUT handshakes.
module tb_ace_rd_arbiter;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } r_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         s0_ar_valid, s0_ar_ready, s0_r_valid, s0_r_ready, s0_r_last;
    logic [31:0]  s0_ar_addr;
    logic [7:0]   s0_ar_len;
    logic [127:0] s0_r_data;
    logic [1:0]   s0_r_resp;
    logic         s1_ar_valid, s1_ar_ready, s1_r_valid, s1_r_ready, s1_r_last;
    logic [31:0]  s1_ar_addr;
    logic [7:0]   s1_ar_len;
    logic [127:0] s1_r_data;
    logic [1:0]   s1_r_resp;
    logic         m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
    logic [31:0]  m_ar_addr;
    logic [7:0]   m_ar_len;
    logic [127:0] m_r_data;
    logic [1:0]   m_r_resp;
    logic [2:0]   outstanding;
    logic         err_orphan;

    int   checks   = 0;
    int   failures = 0;
    ar_t  exp_ar[$];
    r_t   exp_r0[$];
    r_t   exp_r1[$];
    logic own_q[$];
    bit   pend_push = 1'b0;
    logic pend_id   = 1'b0;

    ace_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
        .s0_ar_len(s0_ar_len), .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
        .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
        .s1_ar_len(s1_ar_len), .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
        .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // One cycle: at the falling edge compare routing and every handshake against the
    // scoreboard, then return just after the next rising edge.
    task automatic tick();
        bit   has;
        logic h, ev0, ev1, er;
        ar_t  a;
        r_t   e;
        @(negedge clk);
        has = (own_q.size() > 0);
        h   = has ? own_q[0] : 1'b0;
        ev0 = m_r_valid && has && !h;
        ev1 = m_r_valid && has && h;
        er  = has && (h ? s1_r_ready : s0_r_ready);
        checks++;
        if (s0_r_valid !== ev0 || s1_r_valid !== ev1 || m_r_ready !== er) begin
            failures++;
            $display("FAIL r_route got=v0:%b v1:%b rdy:%b exp=v0:%b v1:%b rdy:%b",
                     s0_r_valid, s1_r_valid, m_r_ready, ev0, ev1, er);
        end
        if (m_ar_valid === 1'b1 && m_ar_ready) begin
            checks++;
            if (exp_ar.size() == 0) begin
                failures++;
                $display("FAIL ar_unexpected got=%h exp=none", m_ar_addr);
            end else begin
                a = exp_ar.pop_front();
                if (m_ar_addr !== a.addr || m_ar_len !== a.len) begin
                    failures++;
                    $display("FAIL ar_out got=%h/%0d exp=%h/%0d", m_ar_addr, m_ar_len, a.addr, a.len);
                end
            end
        end
        if (s0_r_valid === 1'b1 && s0_r_ready) begin
            checks++;
            if (exp_r0.size() == 0) begin
                failures++;
                $display("FAIL r0_unexpected got=%h exp=none", s0_r_data);
            end else begin
                e = exp_r0.pop_front();
                if (s0_r_data !== e.data || s0_r_resp !== e.resp || s0_r_last !== e.last) begin
                    failures++;
                    $display("FAIL r0_beat got=%h/%b/%b exp=%h/%b/%b", s0_r_data, s0_r_resp,
                             s0_r_last, e.data, e.resp, e.last);
                end
            end
        end
        if (s1_r_valid === 1'b1 && s1_r_ready) begin
            checks++;
            if (exp_r1.size() == 0) begin
                failures++;
                $display("FAIL r1_unexpected got=%h exp=none", s1_r_data);
            end else begin
                e = exp_r1.pop_front();
                if (s1_r_data !== e.data || s1_r_resp !== e.resp || s1_r_last !== e.last) begin
                    failures++;
                    $display("FAIL r1_beat got=%h/%b/%b exp=%h/%b/%b", s1_r_data, s1_r_resp,
                             s1_r_last, e.data, e.resp, e.last);
                end
            end
        end
        if (has && m_r_valid && er && m_r_last) void'(own_q.pop_front());
        if (pend_push) own_q.push_back(pend_id);
        pend_push = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Predicts a grant in the current cycle: queue the AR and its owner.
    task automatic expect_grant(input logic id, input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr = addr;
        a.len  = len;
        exp_ar.push_back(a);
        pend_push = 1'b1;
        pend_id   = id;
    endtask

    // Drives one R beat for the head owner and holds it until accepted.
    task automatic send_beat(input logic [127:0] d, input logic last, input bit stall);
        r_t e;
        bit done = 1'b0;
        e.data = d;
        e.resp = d[1:0];
        e.last = last;
        if (own_q.size() > 0 && own_q[0]) exp_r1.push_back(e);
        else                              exp_r0.push_back(e);
        m_r_valid = 1'b1;
        m_r_data  = d;
        m_r_resp  = d[1:0];
        m_r_last  = last;
        for (int i = 0; i < 64 && !done; i++) begin
            s0_r_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s1_r_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            done = m_r_ready;
            tick();
        end
        m_r_valid  = 1'b0;
        m_r_last   = 1'b0;
        s0_r_ready = 1'b1;
        s1_r_ready = 1'b1;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL beat_accept got=stalled exp=accepted");
        end
    endtask

    task automatic idle_inputs();
        s0_ar_valid = 1'b0; s0_ar_addr = '0; s0_ar_len = '0; s0_r_ready = 1'b1;
        s1_ar_valid = 1'b0; s1_ar_addr = '0; s1_ar_len = '0; s1_r_ready = 1'b1;
        m_ar_ready  = 1'b1; m_r_valid  = 1'b0; m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0;
    endtask

    task automatic clear_model();
        exp_ar.delete(); exp_r0.delete(); exp_r1.delete(); own_q.delete();
        pend_push = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        clear_model();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        s0_ar_valid = 1'b1;
        s1_ar_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s0_ar_ready !== 1'b0 || s1_ar_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ar_ready got=%b%b exp=00", s0_ar_ready, s1_ar_ready);
        end
        checks++;
        if (m_ar_valid !== 1'b0 || m_r_ready !== 1'b0 || s0_r_valid !== 1'b0 || s1_r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valids got=%b%b%b%b exp=0000", m_ar_valid, m_r_ready, s0_r_valid, s1_r_valid);
        end
        checks++;
        if (outstanding !== 3'd0 || err_orphan !== 1'b0) begin
            failures++;
            $display("FAIL rst_status got=%0d/%b exp=0/0", outstanding, err_orphan);
        end
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_ifu();
        s0_ar_valid = 1'b1; s0_ar_addr = 32'h1000; s0_ar_len = 8'd0;
        #2;
        checks++;
        if (s0_ar_ready !== 1'b1 || s1_ar_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_grant got=%b%b exp=10", s0_ar_ready, s1_ar_ready);
        end
        expect_grant(1'b0, 32'h1000, 8'd0);
        tick();
        s0_ar_valid = 1'b0;
        checks++;
        if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'h1000) begin
            failures++;
            $display("FAIL single_ar_latency got=%b/%h exp=1/00001000", m_ar_valid, m_ar_addr);
        end
        checks++;
        if (outstanding !== 3'd1) begin
            failures++;
            $display("FAIL single_outstanding1 got=%0d exp=1", outstanding);
        end
        tick();
        checks++;
        if (m_ar_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_ar_drop got=%b exp=0", m_ar_valid);
        end
        send_beat({16{8'hA5}}, 1'b1, 1'b0);
        checks++;
        if (outstanding !== 3'd0) begin
            failures++;
            $display("FAIL single_outstanding0 got=%0d exp=0", outstanding);
        end
    endtask

    task automatic test_round_robin();
        int   k0 = 0;
        int   k1 = 0;
        logic w;
        m_ar_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0_ar_valid = 1'b1; s0_ar_addr = 32'h2000 + 32'(k0 * 'h40); s0_ar_len = 8'd0;
            s1_ar_valid = 1'b1; s1_ar_addr = 32'h3000 + 32'(k1 * 'h40); s1_ar_len = 8'd0;
`ifdef ACE_RD_ARB_LSU_PRIO_EN
            w = 1'b1;
`else
            w = 1'(i % 2);
`endif
            #2;
            checks++;
            if (s0_ar_ready !== !w || s1_ar_ready !== w) begin
                failures++;
                $display("FAIL rr_grant%0d got=%b%b exp=%b%b", i, s0_ar_ready, s1_ar_ready, !w, w);
            end
            expect_grant(w, w ? s1_ar_addr : s0_ar_addr, 8'd0);
            if (w) k1++;
            else   k0++;
            tick();
        end
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b0;
        checks++;
        if (outstanding !== 3'd4) begin
            failures++;
            $display("FAIL rr_outstanding got=%0d exp=4", outstanding);
        end
        for (int i = 0; i < 4; i++) send_beat({4{32'($urandom)}}, 1'b1, 1'b0);
        checks++;
        if (outstanding !== 3'd0) begin
            failures++;
            $display("FAIL rr_drain got=%0d exp=0", outstanding);
        end
    endtask

    task automatic test_fifo_full();
        r_t e;
        m_ar_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0_ar_valid = 1'b1; s0_ar_addr = 32'h4000 + 32'(i * 'h40); s0_ar_len = 8'd0;
            #2;
            checks++;
            if (s0_ar_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_fill%0d got=%b exp=1", i, s0_ar_ready);
            end
            expect_grant(1'b0, s0_ar_addr, 8'd0);
            tick();
        end
        s0_ar_addr = 32'h4100;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (s0_ar_ready !== 1'b0 || outstanding !== 3'd4) begin
                failures++;
                $display("FAIL full_block%0d got=%b/%0d exp=0/4", i, s0_ar_ready, outstanding);
            end
            tick();
        end
        e.data = 128'hFEED_0000_0000_0000_0000_0000_0000_0001;
        e.resp = 2'b01;
        e.last = 1'b1;
        exp_r0.push_back(e);
        m_r_valid = 1'b1; m_r_data = e.data; m_r_resp = e.resp; m_r_last = 1'b1;
        #2;
        checks++;
        if (s0_ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_grant got=%b exp=1", s0_ar_ready);
        end
        expect_grant(1'b0, 32'h4100, 8'd0);
        tick();
        s0_ar_valid = 1'b0;
        m_r_valid   = 1'b0;
        m_r_last    = 1'b0;
        checks++;
        if (outstanding !== 3'd4) begin
            failures++;
            $display("FAIL full_steady got=%0d exp=4", outstanding);
        end
        tick();
        for (int i = 0; i < 4; i++) send_beat({4{32'($urandom)}}, 1'b1, 1'b0);
    endtask

    task automatic test_burst_stalls();
        m_ar_ready = 1'b1;
        s0_ar_valid = 1'b1; s0_ar_addr = 32'h5000; s0_ar_len = 8'd3;
        #2;
        checks++;
        if (s0_ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL burst_grant0 got=%b exp=1", s0_ar_ready);
        end
        expect_grant(1'b0, 32'h5000, 8'd3);
        tick();
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b1; s1_ar_addr = 32'h6000; s1_ar_len = 8'd0;
        #2;
        checks++;
        if (s1_ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL burst_grant1 got=%b exp=1", s1_ar_ready);
        end
        expect_grant(1'b1, 32'h6000, 8'd0);
        tick();
        s1_ar_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_beat({4{32'($urandom)}}, 1'(i == 3), 1'b1);
        send_beat({4{32'($urandom)}}, 1'b1, 1'b1);
        checks++;
        if (exp_r0.size() != 0 || exp_r1.size() != 0 || outstanding !== 3'd0) begin
            failures++;
            $display("FAIL burst_done got=%0d/%0d/%0d exp=0/0/0", exp_r0.size(), exp_r1.size(), outstanding);
        end
    endtask

    task automatic test_ar_stall();
        m_ar_ready = 1'b0;
        s0_ar_valid = 1'b1; s0_ar_addr = 32'h7000; s0_ar_len = 8'd2;
        #2;
        checks++;
        if (s0_ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_grant0 got=%b exp=1", s0_ar_ready);
        end
        expect_grant(1'b0, 32'h7000, 8'd2);
        tick();
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b1; s1_ar_addr = 32'h7100; s1_ar_len = 8'd0;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (s1_ar_ready !== 1'b0 || m_ar_valid !== 1'b1 || m_ar_addr !== 32'h7000 || m_ar_len !== 8'd2) begin
                failures++;
                $display("FAIL stall_hold%0d got=%b/%b/%h/%0d exp=0/1/00007000/2", i,
                         s1_ar_ready, m_ar_valid, m_ar_addr, m_ar_len);
            end
            tick();
        end
        m_ar_ready = 1'b1;
        #2;
        checks++;
        if (s1_ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%b exp=1", s1_ar_ready);
        end
        expect_grant(1'b1, 32'h7100, 8'd0);
        tick();
        s1_ar_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) send_beat({4{32'($urandom)}}, 1'(i == 2), 1'b0);
        send_beat({4{32'($urandom)}}, 1'b1, 1'b0);
        checks++;
        if (outstanding !== 3'd0) begin
            failures++;
            $display("FAIL stall_drain got=%0d exp=0", outstanding);
        end
    endtask

    task automatic test_orphan();
        m_r_valid = 1'b1; m_r_data = 128'h0BAD; m_r_resp = 2'b00; m_r_last = 1'b1;
        #2;
        checks++;
        if (m_r_ready !== 1'b0) begin
            failures++;
            $display("FAIL orphan_ready got=%b exp=0", m_r_ready);
        end
        tick();
        checks++;
        if (err_orphan !== 1'b1) begin
            failures++;
            $display("FAIL orphan_set got=%b exp=1", err_orphan);
        end
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        tick();
        tick();
        checks++;
        if (err_orphan !== 1'b1) begin
            failures++;
            $display("FAIL orphan_sticky got=%b exp=1", err_orphan);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic w;
        m_ar_ready = 1'b1;
        s0_ar_valid = 1'b1; s0_ar_addr = 32'h8000; s0_ar_len = 8'd3;
        #2;
        expect_grant(1'b0, 32'h8000, 8'd3);
        tick();
        s0_ar_valid = 1'b0;
        tick();
        send_beat({4{32'($urandom)}}, 1'b0, 1'b0);
        send_beat({4{32'($urandom)}}, 1'b0, 1'b0);
        s0_ar_valid = 1'b1; s0_ar_addr = 32'h9000; s0_ar_len = 8'd0;
        m_r_valid = 1'b1; m_r_data = 128'h1234; m_r_last = 1'b0; s0_r_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (m_ar_valid !== 1'b0 || s0_ar_ready !== 1'b0 || s1_ar_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_ar got=%b%b%b exp=000", m_ar_valid, s0_ar_ready, s1_ar_ready);
        end
        checks++;
        if (m_r_ready !== 1'b0 || s0_r_valid !== 1'b0 || s1_r_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_r got=%b%b%b exp=000", m_r_ready, s0_r_valid, s1_r_valid);
        end
        checks++;
        if (outstanding !== 3'd0 || err_orphan !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_status got=%0d/%b exp=0/0", outstanding, err_orphan);
        end
        clear_model();
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        // Last grant before reset went to port 0; after reset the pointer is back at port 0.
        s0_ar_valid = 1'b1; s0_ar_addr = 32'hA000; s0_ar_len = 8'd0;
        s1_ar_valid = 1'b1; s1_ar_addr = 32'hB000; s1_ar_len = 8'd0;
`ifdef ACE_RD_ARB_LSU_PRIO_EN
        w = 1'b1;
`else
        w = 1'b0;
`endif
        #2;
        checks++;
        if (s0_ar_ready !== !w || s1_ar_ready !== w) begin
            failures++;
            $display("FAIL post_rst_ptr got=%b%b exp=%b%b", s0_ar_ready, s1_ar_ready, !w, w);
        end
        expect_grant(w, w ? 32'hB000 : 32'hA000, 8'd0);
        tick();
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b0;
        tick();
        send_beat({4{32'($urandom)}}, 1'b1, 1'b0);
    endtask

    task automatic test_final();
        tick();
        checks++;
        if (exp_ar.size() != 0 || exp_r0.size() != 0 || exp_r1.size() != 0 || outstanding !== 3'd0) begin
            failures++;
            $display("FAIL final_empty got=%0d/%0d/%0d/%0d exp=0/0/0/0", exp_ar.size(),
                     exp_r0.size(), exp_r1.size(), outstanding);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_ifu();
        do_reset();
        test_round_robin();
        test_fifo_full();
        test_burst_stalls();
        test_ar_stall();
        test_orphan();
        test_reset_mid_burst();
        test_final();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ace_rd_arbiter.md
Name: ace_rd_arbiter

Overview:
- Shares one downstream cache-line read channel (AR/R subset of ACE) between two requesters: port 0 = IFU (L1I line fills), port 1 = LSU (load misses).
- Sits between the core's fetch/load units and the external ACE master port, so the core exposes a single read port.
- Downstream returns R bursts strictly in AR order (single ID).
- The arbiter keeps an owner-order FIFO so every R beat is routed back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 128, R data width (one cache block).
- MAX_OUTSTANDING, 4, maximum in-flight AR transactions. Power of 2, at least 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s0_ar_valid  in  1  IFU read request valid.
- s0_ar_ready  out  1  IFU request accepted.
- s0_ar_addr  in  ADDR_WIDTH  IFU request address.
- s0_ar_len  in  8  IFU burst length minus 1.
- s0_r_valid  out  1  beat valid to IFU.
- s0_r_ready  in  1  IFU accepts beat.
- s0_r_data  out  DATA_WIDTH  beat data.
- s0_r_resp  out  2  beat response.
- s0_r_last  out  1  last beat.
- s1_*  same set as s0_*, LSU side.
- m_ar_valid  out  1  downstream request valid.
- m_ar_ready  in  1  downstream accepts.
- m_ar_addr  out  ADDR_WIDTH  downstream address.
- m_ar_len  out  8  downstream burst length minus 1.
- m_r_valid  in  1  downstream beat valid.
- m_r_ready  out  1  arbiter accepts beat.
- m_r_data  in  DATA_WIDTH  downstream beat data.
- m_r_resp  in  2  downstream beat response.
- m_r_last  in  1  downstream last beat.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  in-flight transaction count.
- err_orphan  out  1  sticky error: R beat arrived with nothing outstanding.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - m_ar_valid=0, s0/s1_ar_ready=0, m_r_ready=0, s*_r_valid=0.
  - outstanding=0, err_orphan=0.
  - Owner FIFO empty; round-robin pointer points to port 0.
  - Any in-flight AR or burst is dropped.
- AR output register (states EMPTY/FULL):
  - `can_load = (EMPTY | (m_ar_valid & m_ar_ready)) & !fifo_full_after_pop`.
  - `fifo_full_after_pop` is true when count == MAX_OUTSTANDING and no pop occurs this cycle.
  - While FULL, m_ar_addr/len stay stable until m_ar_ready.
- Grant (combinational, only when can_load):
  - Exactly one s*_ar_ready is asserted, to the winner.
  - Winner selection:
    - Only one port valid: that port wins.
    - Both valid: the port the round-robin pointer points to wins.
  - On grant (s*_ar_valid & s*_ar_ready):
    - The register loads addr/len; state becomes FULL.
    - The owner ID is pushed into the FIFO.
    - The pointer moves to the other port.
  - s*_ar_ready never depends on m_ar_ready except through can_load.
- Latency: grant in cycle N, m_ar_valid=1 in cycle N+1. Back-to-back grants sustain 1 AR/cycle if m_ar_ready stays high.
- Owner FIFO:
  - Depth MAX_OUTSTANDING.
  - Push on grant; pop on `m_r_valid & m_r_ready & m_r_last`.
  - Push and pop in the same cycle: count unchanged.
  - Full: no grant unless a pop occurs the same cycle.
  - Read and write pointers wrap modulo depth.
- outstanding = FIFO occupancy, counted from the grant. This includes an AR still held in the register.
- R routing (combinational, zero latency):
  - With head owner h: `s{h}_r_valid = m_r_valid`, `m_r_ready = s{h}_r_ready`.
  - data/resp/last are broadcast to both ports; the other port's r_valid = 0.
  - Bursts never interleave.
  - A burst for an AR still in the register cannot occur; downstream cannot respond before acceptance.
- Orphan beat (m_r_valid while FIFO empty): m_r_ready=0, err_orphan set to 1 and held until reset.
- Simultaneous grant and last-beat pop with FIFO empty before the grant: the pop is not possible, so the orphan rule applies.

Optional Feature:
- ACE_RD_ARB_LSU_PRIO_EN defined: fixed priority. Port 1 (LSU) always wins when both are valid; the round-robin pointer is unused.
- Undefined: round-robin as above.

Test Plan:
- Single IFU request, addr 0x1000, len 0, m_ar_ready=1 -> m_ar_valid 1 cycle after grant with addr 0x1000; one R beat (data 0xA5…) appears on s0 only; outstanding goes 1 then 0.
- Both ports valid every cycle (IFU 0x2000+, LSU 0x3000+), m_ar_ready=1 -> m_ar_addr alternates 0x2000, 0x3000, 0x2000… (macro off); LSU-only stream of 0x3000… (macro on).
- Issue 4 ARs with no R returned -> 5th request sees s*_ar_ready=0 and outstanding=4. Return a last beat in the same cycle as the 5th request -> it is granted that cycle, outstanding stays 4.
- IFU len=3 then LSU len=0, downstream returns 4+1 beats with random s*_r_ready stalls -> first 4 beats to s0 with last on the 4th, 1 beat to s1; no beat is lost or duplicated.
- m_ar_ready held 0 for 5 cycles -> m_ar_addr/len stable, no further grants, one pending request waits.
- m_r_valid=1 with nothing outstanding -> m_r_ready=0, err_orphan=1 and sticky. Assert rst mid-burst -> all outputs return to reset values immediately, outstanding=0.
